// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the multi-cycle divider
package div_pkg;

    // Divider control states; encodings are shared with the execute stage.
    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    // aluop encodings the execute stage uses to select this unit
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage : div_pkg

// File: rtl/div.sv
// rtl/div.sv - restoring shift-subtract divider, one quotient bit per clock
module div
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    signed_div_i,
    input  logic [DATA_WIDTH-1:0]   opdata1_i,
    input  logic [DATA_WIDTH-1:0]   opdata2_i,
    input  logic                    start_i,
    input  logic                    annul_i,
    output logic [2*DATA_WIDTH-1:0] result_o,
    output logic                    ready_o
);

    localparam int W = DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(W);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    div_state_e          state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    // {partial remainder, dividend/quotient}; the 33-bit trial remainder is
    // formed from the shifted top half, so its extra bit needs no storage.
    logic [2*W-1:0]      work_q, work_d;
    logic [W-1:0]        divisor_q, divisor_d;
    logic                neg_quot_q, neg_quot_d;
    logic                neg_rem_q, neg_rem_d;
    logic [2*W-1:0]      result_q, result_d;
    logic                ready_q, ready_d;

    logic [W-1:0]        dividend_abs;
    logic [W-1:0]        divisor_abs;
    logic [W:0]          trial_upper;
    logic [W:0]          trial_diff;
    logic [2*W-1:0]      step_work;
    logic [W-1:0]        quot_raw, rem_raw;
    logic [W-1:0]        quot_fix, rem_fix;

    // Magnitudes of the operands; only signed divides fold negatives.
    assign dividend_abs = (signed_div_i && opdata1_i[W-1]) ? -opdata1_i : opdata1_i;
    assign divisor_abs  = (signed_div_i && opdata2_i[W-1]) ? -opdata2_i : opdata2_i;

    // One restoring step: shift left, trial subtract, borrow lands in bit W.
    assign trial_upper = work_q[2*W-1:W-1];
    assign trial_diff  = trial_upper - {1'b0, divisor_q};
    assign step_work   = trial_diff[W] ? {work_q[2*W-2:0], 1'b0}
                                       : {trial_diff[W-1:0], work_q[W-2:0], 1'b1};

    // Sign fix-up: quotient negated on differing signs, remainder follows dividend.
    assign quot_raw = work_q[W-1:0];
    assign rem_raw  = work_q[2*W-1:W];
    assign quot_fix = neg_quot_q ? -quot_raw : quot_raw;
    assign rem_fix  = neg_rem_q  ? -rem_raw  : rem_raw;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIV_FREE;
            cnt_q      <= '0;
            work_q     <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= DIV_RESULT_NOT_READY;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    // Next-state and datapath control for the divide sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            DIV_FREE: begin
                ready_d  = DIV_RESULT_NOT_READY;
                result_d = '0;
                if (start_i == DIV_START && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DIV_BY_ZERO;
                    end else begin
                        state_d    = DIV_ON;
                        cnt_d      = '0;
                        work_d     = {{W{1'b0}}, dividend_abs};
                        divisor_d  = divisor_abs;
                        neg_quot_d = signed_div_i & (opdata1_i[W-1] ^ opdata2_i[W-1]);
                        neg_rem_d  = signed_div_i & opdata1_i[W-1];
                    end
                end
            end
            DIV_BY_ZERO: begin
                state_d  = DIV_END;
                result_d = '0;
                ready_d  = DIV_RESULT_READY;
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                    cnt_d   = '0;
                    ready_d = DIV_RESULT_NOT_READY;
                end else if (cnt_q != CNT_LAST) begin
                    work_d = step_work;
                    cnt_d  = cnt_q + CNT_ONE;
                end else begin
                    result_d = {rem_fix, quot_fix};
                    ready_d  = DIV_RESULT_READY;
                    state_d  = DIV_END;
                    cnt_d    = '0;
                end
            end
            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    state_d  = DIV_FREE;
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = '0;
                end
            end
            default: begin
                state_d = DIV_FREE;
            end
        endcase
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule : div

// File: tb/tb_div.sv
// tb/tb_div.sv - randomized self-checking bench for the divider
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int checks = 0;
    int errors = 0;

    div #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit arithmetic, truncating division, remainder follows dividend.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b, input int pre_annul);
        logic [63:0] exp;
        int lat;
        exp = ref_div(s, a, b);
        @(negedge clk);
        signed_div = s; op1 = a; op2 = b; start = 1'b1; annul = (pre_annul > 0);
        repeat (pre_annul) @(posedge clk);
        if (pre_annul > 0) begin
            @(negedge clk);
            annul = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        op1 = $urandom; op2 = $urandom; signed_div = 1'($urandom);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ready && lat < 60);
        check("latency", 64'(lat), (b == 32'd0) ? 64'd1 : 64'd33);
        check("result", result, exp);
        @(negedge clk);
        annul = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("hold_ready", 64'(ready), 64'd1);
        check("hold_result", result, exp);
        @(negedge clk);
        annul = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("drop_ready", 64'(ready), 64'd0);
        check("drop_result", result, 64'd0);
        @(negedge clk);
    endtask

    initial begin
        logic seen;
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        do_div(1'b0, 32'd100, 32'd7, 0);
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0);
        do_div(1'b0, 32'd1234, 32'd0, 0);
        do_div(1'b1, 32'hDEAD_BEEF, 32'd0, 0);
        do_div(1'b0, 32'd50, 32'd5, 4);

        // Abort at iteration 10: no result may ever appear.
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'hFFFF_0000; op2 = 32'd3; start = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        annul = 1'b1; start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        annul = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready) seen = 1'b1;
        end
        check("annul_no_ready", 64'(seen), 64'd0);
        do_div(1'b0, 32'd9, 32'd3, 0);

        // Reset at iteration 20.
        @(negedge clk);
        signed_div = 1'b1; op1 = 32'h1234_5678; op2 = 32'd17; start = 1'b1;
        repeat (21) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_ready", 64'(ready), 64'd0);
        check("midrst_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        do_div(1'b1, 32'h1234_5678, 32'd17, 0);

        for (int i = 0; i < 20; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                0: b = b & 32'h0000_00FF;
                1: b = 32'd0;
                2: a = a & 32'h0000_FFFF;
                default: ;
            endcase
            do_div(1'($urandom), a, b, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_div
